// File: rtl/aq_djpeg_bitbuf_if.sv
// Stream bundle between the JPEG bit buffer, its word source
// and the Huffman decoder that consumes the peek window.
interface aq_djpeg_bitbuf_if #(
    parameter int IN_W   = 32,
    parameter int BUF_W  = 96,
    parameter int PEEK_W = 32
);
    localparam int CNT_W = $clog2(BUF_W + 1);
    localparam int USE_W = $clog2(PEEK_W + 1);

    logic [IN_W-1:0]   DataIn;
    logic              DataInEnable;
    logic              DataInRead;
    logic              DataInReq;
    logic              ImageEnable;
    logic              ProcessIdle;
    logic [PEEK_W-1:0] PeekData;
    logic              PeekValid;
    logic [CNT_W-1:0]  BitCount;
    logic              UseBit;
    logic [USE_W-1:0]  UseWidth;
    logic              AlignByte;
    logic              MarkerFound;
    logic [7:0]        MarkerCode;
    logic              MarkerAck;
    logic              DataEnd;
    logic              Underflow;

    modport slave (
        input  DataIn, DataInEnable, ImageEnable, ProcessIdle,
        input  UseBit, UseWidth, AlignByte, MarkerAck,
        output DataInRead, DataInReq, PeekData, PeekValid,
        output BitCount, MarkerFound, MarkerCode, DataEnd, Underflow
    );

    modport master (
        output DataIn, DataInEnable, ImageEnable, ProcessIdle,
        output UseBit, UseWidth, AlignByte, MarkerAck,
        input  DataInRead, DataInReq, PeekData, PeekValid,
        input  BitCount, MarkerFound, MarkerCode, DataEnd, Underflow
    );
endinterface

// File: rtl/aq_djpeg_bitbuf.sv
// JPEG entropy-stream bit buffer: word unpacker, 0xFF00 destuffing,
// marker/EOI detection and a left-aligned peek window for Huffman decode.
module aq_djpeg_bitbuf #(
    parameter int IN_W      = 32,
    parameter int BUF_W     = 96,
    parameter int PEEK_W    = 32,
    parameter bit MSB_FIRST = 1'b0
) (
    input logic clk,
    input logic rst,
    aq_djpeg_bitbuf_if.slave bus
);
    localparam int NB    = IN_W / 8;
    localparam int CNT_W = $clog2(BUF_W + 1);
    localparam int UC_W  = $clog2(NB + 1);

    typedef enum logic [1:0] {
        S_SCAN,
        S_FF_SEEN,
        S_MARK,
        S_END
    } state_t;

    state_t            state;
    logic [IN_W-1:0]   uBuf;
    logic [UC_W-1:0]   uCnt;
    logic [BUF_W-1:0]  bitBuf;
    logic [CNT_W-1:0]  bitCnt;
    logic              markerFound;
    logic [7:0]        markerCode;
    logic              dataEnd;
    logic              underflow;

    logic [IN_W-1:0]   wordOrd;
    logic [7:0]        curByte;
    logic              byteValid;
    logic              room;
    logic              scanFf;
    logic              active;
    logic              take;
    logic              lastTake;
    logic              loadWord;
    logic              appendEn;
    logic [7:0]        appendByte;
    logic [CNT_W-1:0]  useCnt;
    logic [CNT_W-1:0]  afterUse;
    logic [CNT_W-1:0]  cntNext;
    logic              under;

    // Normalise the input word so byte 0 always sits at the LSB end.
    always_comb begin
        wordOrd = bus.DataIn;
        if (MSB_FIRST) begin
            for (int i = 0; i < NB; i++) begin
                wordOrd[8*i +: 8] = bus.DataIn[IN_W-8-8*i +: 8];
            end
        end
    end

    assign curByte   = uBuf[7:0];
    assign byteValid = (uCnt != '0);
    assign room      = (bitCnt <= CNT_W'(BUF_W - 8));
    assign scanFf    = bus.ImageEnable && (state == S_FF_SEEN);
    assign active    = (state == S_SCAN) || (state == S_FF_SEEN);

    // A byte after FF may be taken without room unless it is a stuffed 00,
    // which still has to append an FF into the buffer.
    assign take = byteValid && active &&
                  (room || (scanFf && (curByte != 8'h00)));

    assign lastTake = take && (uCnt == UC_W'(1));

    assign loadWord = rst && !bus.ProcessIdle && bus.DataInEnable &&
                      !dataEnd && !markerFound &&
                      (!byteValid || lastTake);

    // Decide whether the byte taken this cycle lands in the bit buffer.
    always_comb begin
        appendEn   = 1'b0;
        appendByte = scanFf ? 8'hFF : curByte;
        if (take) begin
            if (!bus.ImageEnable) begin
                appendEn = 1'b1;
            end else if (state == S_SCAN) begin
                appendEn = (curByte != 8'hFF);
            end else begin
                appendEn = (curByte == 8'h00);
            end
        end
    end

    assign useCnt = bus.UseBit ? CNT_W'(bus.UseWidth) : '0;
    assign under  = (useCnt > bitCnt);

    // Next fill level: consume, optional byte align, then append.
    always_comb begin
        afterUse = under ? '0 : (bitCnt - useCnt);
        if (bus.AlignByte) begin
            afterUse[2:0] = 3'b000;
        end
        cntNext = afterUse + (appendEn ? CNT_W'(8) : '0);
    end

    // Unpacker, bit buffer and scan FSM state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_SCAN;
            uBuf        <= '0;
            uCnt        <= '0;
            bitBuf      <= '0;
            bitCnt      <= '0;
            markerFound <= 1'b0;
            markerCode  <= 8'h00;
            dataEnd     <= 1'b0;
            underflow   <= 1'b0;
        end else if (bus.ProcessIdle) begin
            state       <= S_SCAN;
            uBuf        <= '0;
            uCnt        <= '0;
            bitBuf      <= '0;
            bitCnt      <= '0;
            markerFound <= 1'b0;
            markerCode  <= 8'h00;
            dataEnd     <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            if (loadWord) begin
                uBuf <= wordOrd;
                uCnt <= UC_W'(NB);
            end else if (take) begin
                uBuf <= uBuf >> 8;
                uCnt <= uCnt - UC_W'(1);
            end
            if (appendEn) begin
                bitBuf <= {bitBuf[BUF_W-9:0], appendByte};
            end
            bitCnt <= cntNext;
            if (under) begin
                underflow <= 1'b1;
            end
            unique case (state)
                S_SCAN: begin
                    if (take && bus.ImageEnable && (curByte == 8'hFF)) begin
                        state <= S_FF_SEEN;
                    end
                end
                S_FF_SEEN: begin
                    if (take) begin
                        if (!bus.ImageEnable || (curByte == 8'h00)) begin
                            state <= S_SCAN;
                        end else if (curByte == 8'hFF) begin
                            state <= S_FF_SEEN;
                        end else if (curByte == 8'hD9) begin
                            dataEnd <= 1'b1;
                            state   <= S_END;
                        end else begin
                            markerCode  <= curByte;
                            markerFound <= 1'b1;
                            state       <= S_MARK;
                        end
                    end
                end
                S_MARK: begin
                    if (bus.MarkerAck) begin
                        markerFound <= 1'b0;
                        bitCnt      <= '0;
                        state       <= S_SCAN;
                    end
                end
                S_END: begin
                    state <= S_END;
                end
            endcase
        end
    end

    assign bus.DataInRead  = loadWord;
    assign bus.DataInReq   = rst && !bus.ProcessIdle && !dataEnd &&
                             !markerFound && !byteValid;
    assign bus.PeekData    = PEEK_W'({bitBuf, {PEEK_W{1'b0}}} >> bitCnt);
    assign bus.PeekValid   = (bitCnt >= CNT_W'(PEEK_W)) || dataEnd;
    assign bus.BitCount    = bitCnt;
    assign bus.MarkerFound = markerFound;
    assign bus.MarkerCode  = markerCode;
    assign bus.DataEnd     = dataEnd;
    assign bus.Underflow   = underflow;
endmodule

// File: tb/tb_aq_djpeg_bitbuf.sv
// Bench for aq_djpeg_bitbuf: directed scenarios plus randomized
// raw/scan streams checked through a bit-level scoreboard.
module tb_aq_djpeg_bitbuf;
    localparam int IN_W   = 32;
    localparam int IN2_W  = 64;
    localparam int BUF_W  = 96;
    localparam int PEEK_W = 32;

    typedef logic [7:0] byteq_t[$];

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    aq_djpeg_bitbuf_if #(.IN_W(IN_W), .BUF_W(BUF_W), .PEEK_W(PEEK_W)) bus ();
    aq_djpeg_bitbuf_if #(.IN_W(IN2_W), .BUF_W(BUF_W), .PEEK_W(PEEK_W)) bus2 ();

    aq_djpeg_bitbuf #(
        .IN_W(IN_W), .BUF_W(BUF_W), .PEEK_W(PEEK_W), .MSB_FIRST(1'b0)
    ) dut (.clk(clk), .rst(rst), .bus(bus));

    aq_djpeg_bitbuf #(
        .IN_W(IN2_W), .BUF_W(BUF_W), .PEEK_W(PEEK_W), .MSB_FIRST(1'b1)
    ) dut2 (.clk(clk), .rst(rst), .bus(bus2));

    int nChecks = 0;
    int nFails  = 0;
    bit expBits[$];
    bit sbOn     = 1'b0;
    bit feedDone = 1'b0;
    bit mFf      = 1'b0;

    task automatic check(input string name, input logic [63:0] got,
                         input logic [63:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference: JPEG destuffing rules applied byte by byte, result as bits.
    function automatic void modelPush(input byteq_t raw, input bit scan);
        logic [7:0] o;
        bit emit;
        foreach (raw[i]) begin
            emit = 1'b1;
            o    = raw[i];
            if (scan) begin
                if (mFf) begin
                    if (raw[i] == 8'hFF) begin
                        emit = 1'b0;
                    end else begin
                        mFf  = 1'b0;
                        emit = (raw[i] == 8'h00);
                        o    = 8'hFF;
                    end
                end else if (raw[i] == 8'hFF) begin
                    mFf  = 1'b1;
                    emit = 1'b0;
                end
            end
            if (emit) begin
                for (int j = 7; j >= 0; j--) expBits.push_back(o[j]);
            end
        end
    endfunction

    // Scoreboard monitor: every consume pops the oldest expected bits.
    int          mW;
    logic [31:0] mExp;
    logic [31:0] mGot;
    always @(negedge clk) begin
        if (sbOn && bus.UseBit && !bus.ProcessIdle && bus.UseWidth != 0) begin
            mW = int'(bus.UseWidth);
            if (expBits.size() < mW) begin
                check("sb_short", 64'(expBits.size()), 64'(mW));
                expBits.delete();
            end else begin
                mExp = '0;
                for (int i = 0; i < mW; i++) begin
                    mExp = {mExp[30:0], 1'b0} | 32'(expBits.pop_front());
                end
                mGot = bus.PeekData >> (PEEK_W - mW);
                check("sb_peek", 64'(mGot), 64'(mExp));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sendWord(input logic [IN_W-1:0] w);
        int t;
        bus.DataIn       = w;
        bus.DataInEnable = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!bus.DataInRead && t < 300);
        check("send_accept", 64'(bus.DataInRead), 64'd1);
        tick();
    endtask

    task automatic waitCnt(input int target, input string name);
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (bus.BitCount != target && t < 100);
        check(name, 64'(bus.BitCount), 64'(target));
    endtask

    task automatic consume(input int w, input bit align);
        bus.UseBit    = 1'b1;
        bus.UseWidth  = 6'(w);
        bus.AlignByte = align;
        tick();
        bus.UseBit    = 1'b0;
        bus.UseWidth  = '0;
        bus.AlignByte = 1'b0;
    endtask

    task automatic idlePulse();
        bus.DataInEnable = 1'b0;
        bus.ProcessIdle  = 1'b1;
        tick();
        bus.ProcessIdle  = 1'b0;
        mFf = 1'b0;
    endtask

    task automatic randomPhase(input bit scan, input int nWords);
        byteq_t raw;
        byteq_t one;
        int t;
        int lim;
        raw = {};
        while (raw.size() < 4 * nWords) begin
            if (!scan) begin
                raw.push_back(8'($urandom));
            end else begin
                case ($urandom_range(0, 7))
                    0: begin raw.push_back(8'hFF); raw.push_back(8'h00); end
                    1: begin
                        raw.push_back(8'hFF);
                        raw.push_back(8'hFF);
                        raw.push_back(8'h00);
                    end
                    default: raw.push_back(8'($urandom_range(0, 254)));
                endcase
            end
        end
        while (raw.size() % 4 != 0) raw.push_back(8'h5A);
        bus.ImageEnable = scan;
        sbOn     = 1'b1;
        feedDone = 1'b0;
        fork
            begin
                for (int i = 0; i < raw.size(); i += 4) begin
                    one = {raw[i], raw[i+1], raw[i+2], raw[i+3]};
                    modelPush(one, scan);
                    sendWord({raw[i+3], raw[i+2], raw[i+1], raw[i]});
                end
                bus.DataInEnable = 1'b0;
                feedDone = 1'b1;
            end
            begin
                t = 0;
                forever begin
                    tick();
                    if ((feedDone && bus.BitCount == 0 && bus.DataInReq) ||
                        t > 20000) break;
                    lim = (bus.BitCount < PEEK_W) ? int'(bus.BitCount) : PEEK_W;
                    bus.UseBit   = 1'($urandom_range(0, 1));
                    bus.UseWidth = 6'($urandom_range(0, lim));
                    t++;
                end
                bus.UseBit   = 1'b0;
                bus.UseWidth = '0;
            end
        join
        sbOn = 1'b0;
        check(scan ? "drain_scan" : "drain_raw", 64'(expBits.size()), 64'd0);
        check("rand_no_marker", 64'(bus.MarkerFound), 64'd0);
        check("rand_no_underflow", 64'(bus.Underflow), 64'd0);
        expBits.delete();
        idlePulse();
    endtask

    function automatic logic [63:0] mkWord(input int k);
        logic [63:0] w;
        for (int i = 0; i < 8; i++) w[63-8*i -: 8] = 8'(8 * k + i + 1);
        return w;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int k;
        int lastRd;
        int nReads;
        int expB;
        bus.DataIn = '0;  bus.DataInEnable = 1'b1; bus.ImageEnable = 1'b0;
        bus.ProcessIdle = 1'b0; bus.UseBit = 1'b0; bus.UseWidth = '0;
        bus.AlignByte = 1'b0; bus.MarkerAck = 1'b0;
        bus2.DataIn = '0; bus2.DataInEnable = 1'b0; bus2.ImageEnable = 1'b0;
        bus2.ProcessIdle = 1'b0; bus2.UseBit = 1'b0; bus2.UseWidth = '0;
        bus2.AlignByte = 1'b0; bus2.MarkerAck = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cnt", 64'(bus.BitCount), 64'd0);
        check("rst_peek", 64'(bus.PeekData), 64'd0);
        check("rst_pvalid", 64'(bus.PeekValid), 64'd0);
        check("rst_read", 64'(bus.DataInRead), 64'd0);
        check("rst_req", 64'(bus.DataInReq), 64'd0);
        check("rst_flags", 64'({bus.MarkerFound, bus.DataEnd, bus.Underflow}), 64'd0);
        bus.DataInEnable = 1'b0;
        rst = 1'b1;
        tick();
        check("req_after_rst", 64'(bus.DataInReq), 64'd1);

        // Raw mode, LSB-first word unpacking.
        sendWord(32'h44332211);
        sendWord(32'h88776655);
        bus.DataInEnable = 1'b0;
        waitCnt(64, "raw_cnt");
        check("raw_peek0", 64'(bus.PeekData), 64'h11223344);
        tick();
        consume(32, 1'b0);
        @(negedge clk);
        check("raw_peek1", 64'(bus.PeekData), 64'h55667788);
        check("raw_cnt1", 64'(bus.BitCount), 64'd32);
        tick();
        idlePulse();

        // Scan mode destuffing: 12 FF00 34 FFFFFF00 56 78 9A BC.
        bus.ImageEnable = 1'b1;
        sendWord(32'h3400FF12);
        sendWord(32'h00FFFFFF);
        sendWord(32'hBC9A7856);
        bus.DataInEnable = 1'b0;
        waitCnt(64, "stuff_cnt");
        check("stuff_peek0", 64'(bus.PeekData), 64'h12FF34FF);
        tick();
        consume(32, 1'b0);
        @(negedge clk);
        check("stuff_peek1", 64'(bus.PeekData), 64'h56789ABC);
        tick();
        idlePulse();

        // Marker: AB FF D3 CD with another word waiting.
        sendWord(32'hCDD3FFAB);
        bus.DataIn       = 32'h11223344;
        bus.DataInEnable = 1'b1;
        t = 0;
        do begin @(negedge clk); t++; end while (!bus.MarkerFound && t < 50);
        check("mk_found", 64'(bus.MarkerFound), 64'd1);
        check("mk_code", 64'(bus.MarkerCode), 64'hD3);
        check("mk_cnt", 64'(bus.BitCount), 64'd8);
        check("mk_peek", 64'(bus.PeekData), 64'hAB000000);
        repeat (5) @(negedge clk);
        check("mk_hold_read", 64'(bus.DataInRead), 64'd0);
        check("mk_hold_req", 64'(bus.DataInReq), 64'd0);
        check("mk_hold_found", 64'(bus.MarkerFound), 64'd1);
        tick();
        bus.MarkerAck = 1'b1;
        tick();
        bus.MarkerAck = 1'b0;
        @(negedge clk);
        check("mk_ack_found", 64'(bus.MarkerFound), 64'd0);
        check("mk_ack_cnt", 64'(bus.BitCount), 64'd0);
        check("mk_refill", 64'(bus.DataInRead), 64'd1);
        tick();
        bus.DataInEnable = 1'b0;
        waitCnt(40, "mk_after_cnt");
        check("mk_after_peek", 64'(bus.PeekData), 64'hCD443322);
        tick();
        idlePulse();

        // EOI: 80 FF D9 gives zero-padded window and freezes input.
        sendWord(32'h00D9FF80);
        bus.DataInEnable = 1'b0;
        t = 0;
        do begin @(negedge clk); t++; end while (!bus.DataEnd && t < 50);
        check("eoi_end", 64'(bus.DataEnd), 64'd1);
        check("eoi_peek", 64'(bus.PeekData), 64'h80000000);
        check("eoi_pvalid", 64'(bus.PeekValid), 64'd1);
        check("eoi_req", 64'(bus.DataInReq), 64'd0);
        tick();
        bus.DataIn = 32'h55555555;
        bus.DataInEnable = 1'b1;
        bus.MarkerAck = 1'b1;
        @(negedge clk);
        check("eoi_frozen", 64'(bus.DataInRead), 64'd0);
        tick();
        bus.MarkerAck = 1'b0;
        bus.DataInEnable = 1'b0;
        bus.ProcessIdle = 1'b1;
        @(negedge clk);
        check("idle_req", 64'(bus.DataInReq), 64'd0);
        tick();
        bus.ProcessIdle = 1'b0;
        @(negedge clk);
        check("idle_end", 64'(bus.DataEnd), 64'd0);
        check("idle_pvalid", 64'(bus.PeekValid), 64'd0);
        check("idle_cnt", 64'(bus.BitCount), 64'd0);
        check("idle_req_after", 64'(bus.DataInReq), 64'd1);
        tick();

        // Underflow and byte alignment.
        bus.ImageEnable = 1'b0;
        sendWord(32'h04030201);
        bus.DataInEnable = 1'b0;
        waitCnt(32, "uf_fill");
        tick();
        consume(27, 1'b0);
        @(negedge clk);
        check("uf_cnt5", 64'(bus.BitCount), 64'd5);
        check("uf_pre", 64'(bus.Underflow), 64'd0);
        tick();
        consume(9, 1'b0);
        @(negedge clk);
        check("uf_set", 64'(bus.Underflow), 64'd1);
        check("uf_cnt0", 64'(bus.BitCount), 64'd0);
        tick();
        sendWord(32'h08070605);
        bus.DataInEnable = 1'b0;
        waitCnt(32, "al_fill");
        check("uf_sticky", 64'(bus.Underflow), 64'd1);
        tick();
        consume(12, 1'b0);
        @(negedge clk);
        check("al_cnt20", 64'(bus.BitCount), 64'd20);
        tick();
        consume(3, 1'b1);
        @(negedge clk);
        check("al_cnt16", 64'(bus.BitCount), 64'd16);
        check("al_peek", 64'(bus.PeekData), 64'h07080000);
        tick();
        idlePulse();
        check("uf_idle_clear", 64'(bus.Underflow), 64'd0);

        randomPhase(1'b0, 40);
        randomPhase(1'b1, 40);

        // MSB-first 64-bit words with DataInEnable held high.
        k = 0; lastRd = -1; nReads = 0; expB = 5;
        for (int i = 0; i < 64; i++) begin
            tick();
            bus2.DataIn       = mkWord(k);
            bus2.DataInEnable = 1'b1;
            bus2.UseBit       = (i == 20) || (i >= 22);
            bus2.UseWidth     = (i == 20) ? 6'd32 : 6'd8;
            @(negedge clk);
            if (i == 18) begin
                check("m2_full_cnt", 64'(bus2.BitCount), 64'd96);
                check("m2_stall", 64'(bus2.DataInRead), 64'd0);
                check("m2_reads", 64'(nReads), 64'd2);
                check("m2_peek0", 64'(bus2.PeekData), 64'h01020304);
            end
            if (i == 21) begin
                check("m2_peek1", 64'(bus2.PeekData), 64'h05060708);
                check("m2_cnt64", 64'(bus2.BitCount), 64'd64);
            end
            if (i >= 22) begin
                check("m2_byte", 64'(bus2.PeekData[31:24]), 64'(expB));
                expB++;
            end
            if (bus2.DataInRead) begin
                if (lastRd >= 24) check("m2_gap", 64'(i - lastRd), 64'd8);
                lastRd = i;
                nReads++;
                k++;
            end
        end
        tick();
        bus2.DataInEnable = 1'b0;
        bus2.UseBit = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 nChecks, nFails);
        $finish;
    end
endmodule
